// File: rtl/seq_mult_param.sv
// Shift-and-add sequential multiplier, unsigned or sign-magnitude signed.
// One product bit per cycle; the result is registered and held until the next multiply finishes.
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on acceptance
// CALC  | one add/shift iteration per cycle, WIDTH iterations
// FIN   | apply sign, register product, pulse done_o
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               clear_i,
  input  logic [WIDTH-1:0]   M_i,
  input  logic [WIDTH-1:0]   N_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   mcnd_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [WIDTH-1:0]   acc_q;
  logic               neg_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   m_mag;
  logic [WIDTH-1:0]   n_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               accept;
  logic               last_iter;

  // done_o is registered on the FIN exit edge, so the pulse cycle is already IDLE;
  // it still counts as busy and must not accept a new start.
  assign accept    = (state_q == IDLE) && start_i && !done_o && !clear_i;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign busy_o    = (state_q != IDLE) || done_o;

  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as unsigned.
  assign m_mag = (signed_i && M_i[WIDTH-1]) ? -M_i : M_i;
  assign n_mag = (signed_i && N_i[WIDTH-1]) ? -N_i : N_i;

  assign addend = mplr_q[0] ? mcnd_q : '0;
  assign sum    = {1'b0, acc_q} + {1'b0, addend};
  assign prod   = {acc_q, mplr_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_iter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcnd_q   <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        mcnd_q <= m_mag;
        mplr_q <= n_mag;
        acc_q  <= '0;
        cnt_q  <= '0;
        neg_q  <= signed_i & (M_i[WIDTH-1] ^ N_i[WIDTH-1]);
      end else if ((state_q == CALC) && !clear_i) begin
        acc_q  <= sum[WIDTH:1];
        mplr_q <= {sum[0], mplr_q[WIDTH-1:1]};
        cnt_q  <= cnt_q + CW'(1);
      end else if ((state_q == FIN) && !clear_i) begin
        result_o <= neg_q ? -prod : prod;
        done_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param (WIDTH=8): stimulus pushes expected products,
// a done_o monitor pops and compares them; control behaviour is checked inline.
module tb_seq_mult_param;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic         clr;
  logic [W-1:0] m;
  logic [W-1:0] n;
  logic [2*W-1:0] result;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [2*W-1:0] exp_q[$];

  seq_mult_param #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .signed_i (sgn),
    .clear_i  (clr),
    .M_i      (m),
    .N_i      (n),
    .result_o (result),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        check("result", {16'h0, result}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp);
    int lat;
    int busy_cnt;
    start = 1'b1; sgn = s; m = a; n = b;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy) busy_cnt++;
    check("latency", lat, 10);
    check("busy_cycles", busy_cnt, 10);
    tick();
    check("busy_after_done", {31'h0, busy}, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dc;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; clr = 1'b0; m = '0; n = '0;
    #2;
    check("reset_result", {16'h0, result}, 0);
    check("reset_busy", {31'h0, busy}, 0);
    check("reset_done", {31'h0, done}, 0);
    tick();
    tick();
    rst_n = 1'b1;

    do_op(1'b0, 8'd255, 8'd255, 16'hFE01);
    do_op(1'b1, 8'h80, 8'h80, 16'h4000);
    do_op(1'b1, 8'hFF, 8'd127, 16'hFF81);
    do_op(1'b1, 8'h80, 8'd127, 16'hC080);
    do_op(1'b0, 8'd0, 8'd200, 16'h0000);
    do_op(1'b1, 8'd5, 8'hFD, 16'hFFF1);
    do_op(1'b0, 8'd13, 8'd11, 16'h008F);
    do_op(1'b0, 8'h80, 8'h80, 16'h4000);

    // start while busy, and again in the done cycle, must be ignored
    dc = done_count;
    start = 1'b1; sgn = 1'b0; m = 8'd10; n = 8'd10;
    exp_q.push_back(16'h0064);
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; m = 8'd3; n = 8'd3;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("busy_start_done_seen", {31'h0, done}, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", {31'h0, busy}, 0);
    repeat (15) tick();
    check("single_done_pulse", done_count - dc, 1);
    check("result_held", {16'h0, result}, 32'h0064);

    // reset mid-CALC aborts; no done afterwards
    dc = done_count;
    start = 1'b1; m = 8'd7; n = 8'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", {16'h0, result}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_done", {31'h0, done}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("no_done_after_rst", done_count - dc, 0);
    do_op(1'b0, 8'd7, 8'd9, 16'h003F);

    // clear mid-CALC keeps the previous result
    do_op(1'b0, 8'd10, 8'd10, 16'h0064);
    dc = done_count;
    start = 1'b1; m = 8'd5; n = 8'd5;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("busy_before_clear", {31'h0, busy}, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clear_to_idle", {31'h0, busy}, 0);
    check("clear_result_kept", {16'h0, result}, 32'h0064);
    repeat (15) tick();
    check("no_done_after_clear", done_count - dc, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port signed_i  input  1  mode, sampled with start_i: 0 = unsigned, 1 = two's-complement signed.
REQ-006 SHALL have port clear_i  input  1  synchronous abort; returns block to IDLE.
REQ-007 SHALL have port M_i  input  WIDTH  multiplicand, sampled with start_i.
REQ-008 SHALL have port N_i  input  WIDTH  multiplier, sampled with start_i.
REQ-009 SHALL have port result_o  output  2*WIDTH  registered product.
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIN.
REQ-013 IDLE: on start_i=1 at an edge SHALL latch operands, mode and sign, clear the accumulator, load iteration count 0, and go to CALC; start_i=0 stays in IDLE.
REQ-014 Signed mode: latched operands SHALL be magnitudes (|M|, |N| as WIDTH-bit unsigned); result sign = M[WIDTH-1] xor N[WIDTH-1].
REQ-015 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), which fits WIDTH unsigned bits without error.
REQ-016 CALC, each cycle: if multiplier LSB=1, acc = acc + multiplicand using a WIDTH+1-bit sum including carry-out; then {acc,multiplier} shift right by one with the carry entering the MSB.
REQ-017 CALC SHALL run exactly WIDTH iterations, then go to FIN.
REQ-018 FIN SHALL register the product into result_o, negated (two's complement, 2*WIDTH bits) when the signed result sign is 1, assert done_o for that cycle, and return to IDLE.
REQ-019 Latency: with start accepted at edge E0, done_o SHALL be high in the cycle after edge E0+WIDTH+1 (WIDTH+2 cycles start-to-done).
REQ-020 result_o SHALL hold its value from FIN until the next FIN; it SHALL not change during CALC.
REQ-021 busy_o SHALL be high from the cycle after start acceptance through the done_o cycle inclusive.
REQ-022 start_i while busy_o=1, including the done_o cycle, SHALL be ignored with no queuing.
REQ-023 clear_i=1 at any edge SHALL force IDLE, leave result_o unchanged and produce no done_o pulse; clear_i has priority over start_i.
REQ-024 The product SHALL be exact for all operand values; no overflow is possible in 2*WIDTH bits (unsigned max (2^WIDTH-1)^2).
REQ-025 A zero operand SHALL still take the full latency of REQ-019, with no early exit.

Reset
REQ-026 rst_ni=0 SHALL immediately force IDLE, result_o=0, busy_o=0, done_o=0, accumulator and counter 0, independent of clk_i.
REQ-027 Reset asserted mid-CALC SHALL abort the operation, with no done_o after release.
REQ-028 After rst_ni deasserts, the first start_i SHALL be accepted at the next rising edge.

Verification (WIDTH=8)
REQ-029 unsigned 255 x 255 -> done_o 10 cycles after start, result_o=0xFE01.
REQ-030 signed -128 x -128 -> result_o=0x4000; signed -1 x 127 -> result_o=0xFF81; signed -128 x 127 -> 0xC080.
REQ-031 unsigned 0 x 200 -> result_o=0x0000 at full latency, busy_o high for 10 cycles.
REQ-032 start_i with 3x3 issued in cycle 4 of an active 10x10 -> only result 100 (0x0064), one done_o pulse.
REQ-033 rst_ni low in cycle 5 of 7x9 -> outputs 0 immediately, no done_o; a new 7x9 afterwards -> 0x003F.
REQ-034 clear_i in cycle 3 after a prior result 0x0064 -> IDLE next cycle, result_o stays 0x0064, no done_o.
